// File: rtl/idu_operand_stage.sv
// Decode / operand-fetch stage feeding the ALU: RV32I OP and OP-IMM decode,
// integer register file with writeback bypass, one-entry valid/ready output.
module idu_operand_stage #(
  parameter int WORD_LENGTH = 32,
  parameter int NREGS       = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_inst,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [6:0]             out_opcode,
  output logic [2:0]             out_funct3,
  output logic [6:0]             out_funct7,
  output logic [WORD_LENGTH-1:0] out_src1,
  output logic [WORD_LENGTH-1:0] out_src2,
  output logic [4:0]             out_rd,
  output logic                   out_illegal,
  input  logic                   wb_en,
  input  logic [4:0]             wb_rd,
  input  logic [WORD_LENGTH-1:0] wb_data
);

  localparam logic [6:0] OPC_OP  = 7'b0110011;
  localparam logic [6:0] OPC_IMM = 7'b0010011;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [0:0] S_EMPTY = 1'b0;
  localparam logic [0:0] S_FULL  = 1'b1;

  logic [0:0]             r_state;
  logic [WORD_LENGTH-1:0] r_regs [NREGS];

  logic [6:0]             w_opc;
  logic [2:0]             w_f3;
  logic [6:0]             w_f7;
  logic [4:0]             w_rs1;
  logic [4:0]             w_rs2;
  logic                   w_accept;
  logic                   w_is_op;
  logic                   w_is_sll;
  logic                   w_is_srx;
  logic                   w_is_ari;
  logic                   w_alt_ok;
  logic                   w_legal;
  logic [6:0]             w_dec_f7;
  logic [WORD_LENGTH-1:0] w_rs1_val;
  logic [WORD_LENGTH-1:0] w_rs2_val;
  logic [WORD_LENGTH-1:0] w_src1;
  logic [WORD_LENGTH-1:0] w_src2;

  assign w_opc = in_inst[6:0];
  assign w_f3  = in_inst[14:12];
  assign w_f7  = in_inst[31:25];
  assign w_rs1 = in_inst[19:15];
  assign w_rs2 = in_inst[24:20];

  assign out_valid = (r_state == S_FULL);
  assign in_ready  = !out_valid || out_ready;
  assign w_accept  = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (wb_en && wb_rd != 5'd0) begin
      r_regs[wb_rd] <= wb_data;
    end
  end

  // Same-cycle writeback is forwarded so the snapshot sees the newest value.
  always_comb begin
    w_rs1_val = '0;
    w_rs2_val = '0;
    if (w_rs1 != 5'd0)
      w_rs1_val = (wb_en && wb_rd == w_rs1) ? wb_data : r_regs[w_rs1];
    if (w_rs2 != 5'd0)
      w_rs2_val = (wb_en && wb_rd == w_rs2) ? wb_data : r_regs[w_rs2];
  end

  assign w_is_op  = (w_opc == OPC_OP);
  assign w_is_sll = (w_opc == OPC_IMM) && (w_f3 == 3'b001);
  assign w_is_srx = (w_opc == OPC_IMM) && (w_f3 == 3'b101);
  assign w_is_ari = (w_opc == OPC_IMM) && !w_is_sll && !w_is_srx;
  assign w_alt_ok = (w_f3 == 3'b000) || (w_f3 == 3'b101);

  always_comb begin
    w_legal  = 1'b0;
    w_dec_f7 = w_f7;
    w_src1   = w_rs1_val;
    w_src2   = w_rs2_val;
    unique case (1'b1)
      w_is_op: begin
        w_legal = (w_f7 == 7'd0) || (w_f7 == F7_ALT && w_alt_ok);
      end
      w_is_sll: begin
        w_legal = (w_f7 == 7'd0);
        w_src2  = {{(WORD_LENGTH-5){1'b0}}, w_rs2};
      end
      w_is_srx: begin
        w_legal = (w_f7 == 7'd0) || (w_f7 == F7_ALT);
        w_src2  = {{(WORD_LENGTH-5){1'b0}}, w_rs2};
      end
      // Immediate bits must never reach the ALU as a subtract request.
      w_is_ari: begin
        w_legal  = 1'b1;
        w_dec_f7 = 7'd0;
        w_src2   = {{(WORD_LENGTH-12){in_inst[31]}}, in_inst[31:20]};
      end
      default: w_legal = 1'b0;
    endcase
    if (!w_legal) begin
      w_dec_f7 = 7'd0;
      w_src1   = '0;
      w_src2   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_EMPTY;
      out_opcode  <= '0;
      out_funct3  <= '0;
      out_funct7  <= '0;
      out_src1    <= '0;
      out_src2    <= '0;
      out_rd      <= '0;
      out_illegal <= 1'b0;
    end else if (w_accept) begin
      r_state     <= S_FULL;
      out_opcode  <= w_opc;
      out_funct3  <= w_f3;
      out_funct7  <= w_dec_f7;
      out_src1    <= w_src1;
      out_src2    <= w_src2;
      out_rd      <= in_inst[11:7];
      out_illegal <= !w_legal;
    end else if (out_ready) begin
      r_state     <= S_EMPTY;
    end
  end

endmodule
